// File: rtl/text_pkg.sv
// Shared constants and types for the text window renderer: control codes, glyph geometry and
// the write-FSM state type.
package text_pkg;

   localparam logic [7:0] CHR_BS = 8'h08;
   localparam logic [7:0] CHR_FF = 8'h0C;
   localparam logic [7:0] CHR_CR = 8'h0D;
   localparam logic [7:0] CHR_SP = 8'h20;

   localparam int unsigned GLYPH_W = 8;
   localparam int unsigned GLYPH_H = 16;

   typedef enum logic [0:0] {
      StClear,
      StIdle
   } wr_state_e;

endpackage

// File: rtl/text_window_renderer_if.sv
// Character write port of the text window renderer (valid/ready handshake).
interface text_window_renderer_if;

   logic       wr_valid;
   logic [7:0] wr_char;
   logic       wr_ready;

   modport master (output wr_valid, output wr_char, input wr_ready);
   modport slave  (input wr_valid, input wr_char, output wr_ready);

endinterface

// File: rtl/ascii_rom.sv
// Reduced ASCII glyph ROM, address {code[6:0], glyph row}, registered data. 'A' is drawn in
// full; every other printable code shows a hollow box and space/control codes are blank.
module ascii_rom (
   input  logic        clk,
   input  logic [10:0] i_addr,
   output logic [7:0]  o_data
);

   function automatic logic [7:0] glyph(input logic [6:0] code, input logic [3:0] row);
      logic [7:0] d;
      d = 8'h00;
      if (code == 7'h41) begin
         case (row)
            4'd2:              d = 8'h18;
            4'd3:              d = 8'h3C;
            4'd4:              d = 8'h66;
            4'd7, 4'd8:        d = 8'hFF;
            4'd5, 4'd6, 4'd9,
            4'd10, 4'd11, 4'd12: d = 8'hC3;
            default:           d = 8'h00;
         endcase
      end else if (code > 7'h20 && code != 7'h7F) begin
         if (row == 4'd2 || row == 4'd13) begin
            d = 8'h7E;
         end else if (row > 4'd2 && row < 4'd13) begin
            d = 8'h42;
         end
      end
      return d;
   endfunction

   always_ff @(posedge clk) begin
      o_data <= glyph(i_addr[10:4], i_addr[3:0]);
   end

endmodule

// File: rtl/char_buffer.sv
// Simple dual-port character RAM: one synchronous write port, one synchronous read-first read
// port (a same-cycle write to the read cell returns the old code).
module char_buffer #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = 7
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/thai_rom.sv
// Reduced Thai glyph ROM, address {code[6:0], glyph row}, registered data. Only KO KAI (0xA1)
// is drawn; other codes are blank.
module thai_rom (
   input  logic        clk,
   input  logic [10:0] i_addr,
   output logic [7:0]  o_data
);

   function automatic logic [7:0] glyph(input logic [6:0] code, input logic [3:0] row);
      logic [7:0] d;
      d = 8'h00;
      if (code == 7'h21) begin
         if (row == 4'd4) begin
            d = 8'h7E;
         end else if (row > 4'd4 && row < 4'd13) begin
            d = 8'h66;
         end
      end
      return d;
   endfunction

   always_ff @(posedge clk) begin
      o_data <= glyph(i_addr[10:4], i_addr[3:0]);
   end

endmodule

// File: rtl/text_window_renderer.sv
// Text-mode window: cursor-driven write port into a COLS x ROWS buffer plus a 3-stage glyph
// render pipeline. Define TEXT_CURSOR_BLINK_EN to draw a blinking underline cursor.
module text_window_renderer
   import text_pkg::*;
#(
   parameter int unsigned COLS   = 32,
   parameter int unsigned ROWS   = 4,
   parameter int unsigned X0     = 192,
   parameter int unsigned Y0     = 208,
   parameter int unsigned BORDER = 4,
   parameter logic [11:0] FG     = 12'h000,
   parameter logic [11:0] BG     = 12'hFFF,
   parameter logic [11:0] FRAME  = 12'h000,
`ifdef TEXT_CURSOR_BLINK_EN
   parameter int unsigned BLINK_FRAMES = 30,
`endif
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   text_window_renderer_if.slave wr_if,
   input  logic                  video_on,
   input  logic [9:0]            x,
   input  logic [9:0]            y,
   output logic                  busy,
   output logic [CW-1:0]         cursor_col,
   output logic [RW-1:0]         cursor_row,
   output logic [11:0]           rgb
);

   localparam int unsigned CELLS = COLS * ROWS;
   localparam int unsigned AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int WIN_XL = int'(X0);
   localparam int WIN_XR = int'(X0 + GLYPH_W * COLS);
   localparam int WIN_YT = int'(Y0);
   localparam int WIN_YB = int'(Y0 + GLYPH_H * ROWS);
   localparam int FRM_XL = WIN_XL - int'(BORDER);
   localparam int FRM_XR = WIN_XR + int'(BORDER);
   localparam int FRM_YT = WIN_YT - int'(BORDER);
   localparam int FRM_YB = WIN_YB + int'(BORDER);

   function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col);
      return AW'(32'(row) * COLS + 32'(col));
   endfunction

   // ---------------- write FSM ----------------
   wr_state_e     r_state, w_state_nxt;
   logic [AW-1:0] r_clr_addr, w_clr_addr_nxt;
   logic [CW-1:0] r_col, w_col_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [7:0]    w_wdata;
   logic          w_last_col, w_last_row;

   assign w_last_col = (r_col == CW'(COLS - 1));
   assign w_last_row = (r_row == RW'(ROWS - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StClear;
         r_clr_addr <= '0;
         r_col      <= '0;
         r_row      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
         r_col      <= w_col_nxt;
         r_row      <= w_row_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_col_nxt      = r_col;
      w_row_nxt      = r_row;
      w_we           = 1'b0;
      w_waddr        = cell_addr(r_row, r_col);
      w_wdata        = wr_if.wr_char;
      wr_if.wr_ready = 1'b0;
      busy           = 1'b0;
      unique case (r_state)
         StClear: begin
            busy    = 1'b1;
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = CHR_SP;
            if (r_clr_addr == AW'(CELLS - 1)) begin
               w_state_nxt    = StIdle;
               w_clr_addr_nxt = '0;
            end else begin
               w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
         end
         StIdle: begin
            wr_if.wr_ready = 1'b1;
            if (wr_if.wr_valid) begin
               if (wr_if.wr_char == CHR_FF) begin
                  w_col_nxt      = '0;
                  w_row_nxt      = '0;
                  w_clr_addr_nxt = '0;
                  w_state_nxt    = StClear;
               end else if (wr_if.wr_char == CHR_CR) begin
                  w_col_nxt = '0;
                  w_row_nxt = w_last_row ? '0 : r_row + 1'b1;
               end else if (wr_if.wr_char == CHR_BS) begin
                  if (r_col != '0 || r_row != '0) begin
                     if (r_col == '0) begin
                        w_col_nxt = CW'(COLS - 1);
                        w_row_nxt = r_row - 1'b1;
                     end else begin
                        w_col_nxt = r_col - 1'b1;
                     end
                     w_we    = 1'b1;
                     w_waddr = cell_addr(w_row_nxt, w_col_nxt);
                     w_wdata = CHR_SP;
                  end
               end else if (wr_if.wr_char >= 8'h20) begin
                  w_we = 1'b1;
                  if (w_last_col) begin
                     w_col_nxt = '0;
                     w_row_nxt = w_last_row ? '0 : r_row + 1'b1;
                  end else begin
                     w_col_nxt = r_col + 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = StClear;
      endcase
   end

   assign cursor_col = r_col;
   assign cursor_row = r_row;

   // ---------------- render pipeline ----------------
   int            w_xi, w_yi;
   logic          w_in_win, w_in_frm;
   logic [CW-1:0] w_pcol;
   logic [RW-1:0] w_prow;
   logic [AW-1:0] w_raddr;
   logic [7:0]    w_rdata, w_ascii, w_thai, w_glyph;
   logic          w_cur_hit;

   assign w_xi     = int'(x);
   assign w_yi     = int'(y);
   assign w_in_win = (w_xi >= WIN_XL) && (w_xi < WIN_XR) && (w_yi >= WIN_YT) && (w_yi < WIN_YB);
   assign w_in_frm = (w_xi >= FRM_XL) && (w_xi < FRM_XR) && (w_yi >= FRM_YT) && (w_yi < FRM_YB)
                     && !w_in_win;
   assign w_pcol   = CW'((x - 10'(X0)) >> 3);
   assign w_prow   = RW'((y - 10'(Y0)) >> 4);
   // Outside the window the decoded cell is meaningless; keep the RAM address in range.
   assign w_raddr  = w_in_win ? cell_addr(w_prow, w_pcol) : '0;

`ifdef TEXT_CURSOR_BLINK_EN
   localparam int unsigned FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [FCW-1:0] r_frame_cnt;
   logic           r_phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (video_on && x == '0 && y == '0) begin
         if (r_frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
            r_frame_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   assign w_cur_hit = r_phase && w_in_win && (w_pcol == r_col) && (w_prow == r_row)
                      && (y[3:0] >= 4'd14);
`else
   assign w_cur_hit = 1'b0;
`endif

   logic [3:0]  r1_grow;
   logic [2:0]  r1_gbit, r2_gbit;
   logic        r1_win, r1_frm, r1_von, r1_cur;
   logic        r2_win, r2_frm, r2_von, r2_cur, r2_thai;
   logic [11:0] r_rgb;

   char_buffer #(
      .DEPTH (CELLS),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   ascii_rom u_ascii (
      .clk    (clk),
      .i_addr ({w_rdata[6:0], r1_grow}),
      .o_data (w_ascii)
   );

   thai_rom u_thai (
      .clk    (clk),
      .i_addr ({w_rdata[6:0], r1_grow}),
      .o_data (w_thai)
   );

   assign w_glyph = r2_thai ? w_thai : w_ascii;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r1_grow <= '0;
         r1_gbit <= '0;
         r1_win  <= 1'b0;
         r1_frm  <= 1'b0;
         r1_von  <= 1'b0;
         r1_cur  <= 1'b0;
         r2_gbit <= '0;
         r2_win  <= 1'b0;
         r2_frm  <= 1'b0;
         r2_von  <= 1'b0;
         r2_cur  <= 1'b0;
         r2_thai <= 1'b0;
         r_rgb   <= '0;
      end else begin
         r1_grow <= y[3:0];
         r1_gbit <= x[2:0];
         r1_win  <= w_in_win;
         r1_frm  <= w_in_frm;
         r1_von  <= video_on;
         r1_cur  <= w_cur_hit;
         r2_gbit <= r1_gbit;
         r2_win  <= r1_win;
         r2_frm  <= r1_frm;
         r2_von  <= r1_von;
         r2_cur  <= r1_cur;
         r2_thai <= w_rdata[7];
         if (!r2_von) begin
            r_rgb <= 12'h000;
         end else if (r2_win && (w_glyph[3'd7 - r2_gbit] || r2_cur)) begin
            r_rgb <= FG;
         end else if (r2_win) begin
            r_rgb <= BG;
         end else if (r2_frm) begin
            r_rgb <= FRAME;
         end else begin
            r_rgb <= BG;
         end
      end
   end

   assign rgb = r_rgb;

endmodule
